// File: rtl/buck_pwm_gen.sv
// Two-phase interleaved synchronous-buck gate driver.
// Owns the 4 us switching timebase for the upstream one-cycle controller and
// turns its requested on-time into dead-time-separated high/low gate pulses
// for two channels running half a period apart. Enable gating and a sticky
// fault latch both force the gates off; timers keep running regardless.
module buck_pwm_gen #(
  parameter int PERIOD      = 400,
  parameter int PHASE_SHIFT = 200,
  parameter int DEAD_TIME   = 10,
  parameter int MAX_ON      = 200,
  parameter int MIN_ON      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault,
  input  logic        fault_clr,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_1,
  output logic        gate_hi_0,
  output logic        gate_lo_0,
  output logic        gate_hi_1,
  output logic        gate_lo_1,
  output logic [15:0] ton_applied_0,
  output logic [15:0] ton_applied_1,
  output logic        fault_latched
);

  localparam logic [15:0] PERIOD_M1_W = 16'(PERIOD - 1);
  localparam logic [15:0] PHASE_W     = 16'(PHASE_SHIFT);
  localparam logic [15:0] DEAD_W      = 16'(DEAD_TIME);
  localparam logic [15:0] LO_END_W    = 16'(PERIOD - DEAD_TIME);
  localparam logic [15:0] MAX_ON_W    = 16'(MAX_ON);
  localparam logic [15:0] MIN_ON_W    = 16'(MIN_ON);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_A  = 3'd1,
    ST_HI_ON = 3'd2,
    ST_DT_B  = 3'd3,
    ST_LO_ON = 3'd4,
    ST_DT_C  = 3'd5
  } gate_state_t;

  // Saturate long requests, drop pulses too short to switch cleanly.
  function automatic logic [15:0] clamp_ton(input logic [15:0] req);
    logic [15:0] res;
    if (req > MAX_ON_W) begin
      res = MAX_ON_W;
    end else if (req < MIN_ON_W) begin
      res = 16'd0;
    end else begin
      res = req;
    end
    return res;
  endfunction

  logic fault_latched_r;
  logic gate_allow_s;

  // Any live fault, latched fault or missing enable blocks gating this cycle.
  assign gate_allow_s = enable & ~fault & ~fault_latched_r;

  // Sticky fault latch; a live fault overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_latched_r <= 1'b0;
    end else if (fault) begin
      fault_latched_r <= 1'b1;
    end else if (fault_clr) begin
      fault_latched_r <= 1'b0;
    end else begin
      fault_latched_r <= fault_latched_r;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    localparam logic [15:0] TIMER_INIT = (ch == 0) ? 16'd0 : PHASE_W;

    logic [15:0] timer_r;
    logic [15:0] ton_r;
    logic [15:0] hi_end_s;
    logic [15:0] lo_start_s;
    logic        wrap_s;
    logic        run_r;
    logic        run_nxt_s;
    logic        hi_req_s;
    logic        lo_req_s;
    logic        hi_r;
    logic        lo_r;
    gate_state_t phase_s;
    gate_state_t state_nxt_s;
    gate_state_t state_r;

    assign wrap_s     = (timer_r == PERIOD_M1_W);
    assign hi_end_s   = DEAD_W + ton_r;
    assign lo_start_s = hi_end_s + DEAD_W;

    // Free-running period counter; never gated so the upstream cadence holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        timer_r <= TIMER_INIT;
      end else if (wrap_s) begin
        timer_r <= 16'd0;
      end else begin
        timer_r <= timer_r + 16'd1;
      end
    end

    // Shadow on-time: captured only at the wrap, held for the whole period.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ton_r <= 16'd0;
      end else if (wrap_s) begin
        ton_r <= clamp_ton(inductor_charging_time);
      end else begin
        ton_r <= ton_r;
      end
    end

    // Run flag arms only at a wrap and drops as soon as enable or the latch goes bad.
    always_comb begin
      run_nxt_s = 1'b0;
      if (wrap_s) begin
        run_nxt_s = enable & ~fault_latched_r;
      end else begin
        run_nxt_s = run_r & enable & ~fault_latched_r;
      end
    end

    // Run flag register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run_r <= 1'b0;
      end else begin
        run_r <= run_nxt_s;
      end
    end

    // Locate the timer inside the period to find the phase the gates should be in.
    always_comb begin
      phase_s = ST_OFF;
      if (!(run_r && gate_allow_s)) begin
        phase_s = ST_OFF;
      end else if (timer_r < DEAD_W) begin
        phase_s = ST_DT_A;
      end else if (timer_r < hi_end_s) begin
        phase_s = ST_HI_ON;
      end else if (timer_r < lo_start_s) begin
        phase_s = ST_DT_B;
      end else if (timer_r < LO_END_W) begin
        phase_s = ST_LO_ON;
      end else begin
        phase_s = ST_DT_C;
      end
    end

    // A conducting state may only be entered from its own dead-time state,
    // so no path can bypass the both-off interval.
    always_comb begin
      state_nxt_s = phase_s;
      hi_req_s    = 1'b0;
      lo_req_s    = 1'b0;
      case (phase_s)
        ST_HI_ON: begin
          if (state_r == ST_DT_A || state_r == ST_HI_ON) begin
            hi_req_s = 1'b1;
          end else begin
            state_nxt_s = ST_OFF;
          end
        end
        ST_LO_ON: begin
          if (state_r == ST_DT_B || state_r == ST_LO_ON) begin
            lo_req_s = 1'b1;
          end else begin
            state_nxt_s = ST_OFF;
          end
        end
        default: begin
          hi_req_s = 1'b0;
          lo_req_s = 1'b0;
        end
      endcase
    end

    // Gate state plus final registered interlock: a shoot-through request turns both off.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_OFF;
        hi_r    <= 1'b0;
        lo_r    <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        if (hi_req_s && lo_req_s) begin
          hi_r <= 1'b0;
          lo_r <= 1'b0;
        end else begin
          hi_r <= hi_req_s;
          lo_r <= lo_req_s;
        end
      end
    end
  end

  assign timer_buck_4us_0 = g_ch[0].timer_r;
  assign timer_buck_4us_1 = g_ch[1].timer_r;
  assign ton_applied_0    = g_ch[0].ton_r;
  assign ton_applied_1    = g_ch[1].ton_r;
  assign gate_hi_0        = g_ch[0].hi_r;
  assign gate_lo_0        = g_ch[0].lo_r;
  assign gate_hi_1        = g_ch[1].hi_r;
  assign gate_lo_1        = g_ch[1].lo_r;
  assign fault_latched    = fault_latched_r;

endmodule

// File: tb/tb_buck_pwm_gen.sv
// Bench for buck_pwm_gen: clamp table, hand-written multi-cycle sequences and
// a randomized run, all checked every cycle against a behavioural model that
// derives timers from elapsed cycles and gates from the period window rules.
`timescale 1ns/1ps
module tb_buck_pwm_gen;
  localparam int PERIOD = 400;
  localparam int PHASE  = 200;
  localparam int DT     = 10;
  localparam int MAX_ON = 200;
  localparam int MIN_ON = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic [15:0] ict = 16'd0;
  logic [15:0] timer0, timer1, ton0, ton1;
  logic        hi0, lo0, hi1, lo1, fl;

  buck_pwm_gen dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .fault_clr(fault_clr),
    .inductor_charging_time(ict),
    .timer_buck_4us_0(timer0), .timer_buck_4us_1(timer1),
    .gate_hi_0(hi0), .gate_lo_0(lo0), .gate_hi_1(hi1), .gate_lo_1(lo1),
    .ton_applied_0(ton0), .ton_applied_1(ton1), .fault_latched(fl)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural reference model ----------------
  int m_cyc;
  int m_ton [2];
  bit m_armed [2];
  bit m_hi [2];
  bit m_lo [2];
  bit m_fl;

  function automatic int clamp_ref(int v);
    if (v > MAX_ON) return MAX_ON;
    if (v < MIN_ON) return 0;
    return v;
  endfunction

  function automatic int model_pos(int ch);
    return (m_cyc + ch * PHASE) % PERIOD;
  endfunction

  function automatic bit in_hi(int p, int ton);
    return (p >= DT) && (p < DT + ton);
  endfunction

  function automatic bit in_lo(int p, int ton);
    return (p >= 2 * DT + ton) && (p < PERIOD - DT);
  endfunction

  // Model state advances on each clock; outputs are what the DUT should show after the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
      m_fl  <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_ton[ch]   <= 0;
        m_armed[ch] <= 1'b0;
        m_hi[ch]    <= 1'b0;
        m_lo[ch]    <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_hi[ch] <= m_armed[ch] && enable && !fault && !m_fl && in_hi(model_pos(ch), m_ton[ch]);
        m_lo[ch] <= m_armed[ch] && enable && !fault && !m_fl && in_lo(model_pos(ch), m_ton[ch]);
        if (model_pos(ch) == PERIOD - 1) begin
          m_ton[ch]   <= clamp_ref(int'(ict));
          m_armed[ch] <= enable && !m_fl;
        end else if (!enable || m_fl) begin
          m_armed[ch] <= 1'b0;
        end
      end
      m_fl  <= fault || (m_fl && !fault_clr);
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int last_on [2];
  int off_cnt [2];

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic interlock();
    logic [1:0] h, l;
    h = {hi1, hi0};
    l = {lo1, lo0};
    for (int ch = 0; ch < 2; ch++) begin
      checks++;
      if (h[ch] && l[ch]) begin
        errors++;
        $display("FAIL overlap_ch%0d: hi=1 lo=1 at t=%0d required never both", ch, ch == 0 ? timer0 : timer1);
      end else if (h[ch]) begin
        if (last_on[ch] == 2 && off_cnt[ch] < DT) begin
          errors++;
          $display("FAIL deadtime_ch%0d: lo->hi gap %0d required >= %0d", ch, off_cnt[ch], DT);
        end
        last_on[ch] = 1;
        off_cnt[ch] = 0;
      end else if (l[ch]) begin
        if (last_on[ch] == 1 && off_cnt[ch] < DT) begin
          errors++;
          $display("FAIL deadtime_ch%0d: hi->lo gap %0d required >= %0d", ch, off_cnt[ch], DT);
        end
        last_on[ch] = 2;
        off_cnt[ch] = 0;
      end else begin
        off_cnt[ch] = off_cnt[ch] + 1;
      end
    end
  endtask

  task automatic step();
    logic [127:0] act, exp;
    @(negedge clk);
    act = {timer0, timer1, ton0, ton1, hi0, lo0, hi1, lo1, fl};
    exp = {16'(model_pos(0)), 16'(model_pos(1)), 16'(m_ton[0]), 16'(m_ton[1]),
           m_hi[0], m_lo[0], m_hi[1], m_lo[1], m_fl};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_%0d: got %0h expected %0h", m_cyc, act, exp);
    end
    interlock();
  endtask

  task automatic wait_until(int ch, int val);
    int n;
    n = 0;
    while (model_pos(ch) != val && n < 2 * PERIOD + 4) begin
      step();
      n++;
    end
  endtask

  task automatic measure(int ch, output int ton_at0, output int hi_first, output int hi_cnt,
                         output int lo_first, output int lo_cnt);
    int t;
    logic h, l;
    ton_at0  = (ch == 0) ? int'(ton0) : int'(ton1);
    hi_first = -1; hi_cnt = 0; lo_first = -1; lo_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      t = (ch == 0) ? int'(timer0) : int'(timer1);
      h = (ch == 0) ? hi0 : hi1;
      l = (ch == 0) ? lo0 : lo1;
      if (h) begin
        if (hi_first < 0) hi_first = t;
        hi_cnt++;
      end
      if (l) begin
        if (lo_first < 0) lo_first = t;
        lo_cnt++;
      end
      step();
    end
  endtask

  typedef struct {
    logic [15:0] ict;
    int          exp_ton;
    int          exp_hi;
    int          exp_lo_first;
    int          exp_lo;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r_ton, r_hf, r_hc, r_lf, r_lc;

    vecs[0] = '{16'd100,   100, 100, 121, 270};
    vecs[1] = '{16'd350,   200, 200, 221, 170};
    vecs[2] = '{16'd3,     0,   0,   21,  370};
    vecs[3] = '{16'd4,     4,   4,   25,  366};
    vecs[4] = '{16'd0,     0,   0,   21,  370};
    vecs[5] = '{16'd200,   200, 200, 221, 170};
    vecs[6] = '{16'd201,   200, 200, 221, 170};
    vecs[7] = '{16'd65535, 200, 200, 221, 170};
    vecs[8] = '{16'd199,   199, 199, 220, 171};
    for (int ch = 0; ch < 2; ch++) begin
      last_on[ch] = 0;
      off_cnt[ch] = 0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check_int("rst_timer0", int'(timer0), 0);
    check_int("rst_timer1", int'(timer1), PHASE);
    check_int("rst_gates", int'({hi0, lo0, hi1, lo1}), 0);
    check_int("rst_ton", int'(ton0) + int'(ton1), 0);
    check_int("rst_fault", int'(fl), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    ict    = 16'd100;

    // Clamp table on channel 0
    for (int i = 0; i < 9; i++) begin
      ict = vecs[i].ict;
      wait_until(0, 1);
      wait_until(0, 0);
      measure(0, r_ton, r_hf, r_hc, r_lf, r_lc);
      check_int($sformatf("vec%0d_ton", i), r_ton, vecs[i].exp_ton);
      check_int($sformatf("vec%0d_hi_cnt", i), r_hc, vecs[i].exp_hi);
      check_int($sformatf("vec%0d_hi_first", i), r_hf, (vecs[i].exp_hi > 0) ? DT + 1 : -1);
      check_int($sformatf("vec%0d_lo_first", i), r_lf, vecs[i].exp_lo_first);
      check_int($sformatf("vec%0d_lo_cnt", i), r_lc, vecs[i].exp_lo);
    end

    // Channel 1 nominal pattern on its own timer
    ict = 16'd100;
    wait_until(1, 1);
    wait_until(1, 0);
    measure(1, r_ton, r_hf, r_hc, r_lf, r_lc);
    check_int("ch1_ton", r_ton, 100);
    check_int("ch1_hi_first", r_hf, 11);
    check_int("ch1_hi_cnt", r_hc, 100);
    check_int("ch1_lo_first", r_lf, 121);
    check_int("ch1_lo_cnt", r_lc, 270);

    // Mid-period change: current pulse held, next period uses the new value
    wait_until(0, 1);
    wait_until(0, 0);
    wait_until(0, 50);
    ict = 16'd50;
    wait_until(0, 110);
    check_int("mid_hi_held", int'(hi0), 1);
    step();
    check_int("mid_hi_end", int'(hi0), 0);
    check_int("mid_ton_held", int'(ton0), 100);
    wait_until(0, 0);
    measure(0, r_ton, r_hf, r_hc, r_lf, r_lc);
    check_int("mid_next_ton", r_ton, 50);
    check_int("mid_next_hi_cnt", r_hc, 50);

    // Fault during HI_ON
    ict = 16'd100;
    wait_until(0, 1);
    wait_until(0, 0);
    wait_until(0, 60);
    check_int("fault_pre_hi", int'(hi0), 1);
    fault = 1'b1;
    step();
    check_int("fault_gates_off", int'({hi0, lo0, hi1, lo1}), 0);
    check_int("fault_latched", int'(fl), 1);
    check_int("fault_timer_runs", int'(timer0), 61);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check_int("fault_clr_ignored", int'(fl), 1);
    fault = 1'b0;
    step();
    step();
    check_int("fault_sticky", int'(fl), 1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check_int("fault_cleared", int'(fl), 0);
    wait_until(1, 11);
    check_int("fault_ch1_resume", int'(hi1), 1);
    check_int("fault_ch0_still_off", int'(lo0), 0);
    wait_until(0, 11);
    check_int("fault_ch0_resume", int'(hi0), 1);

    // Enable drop and late re-enable
    wait_until(0, 130);
    check_int("en_pre_lo", int'(lo0), 1);
    enable = 1'b0;
    step();
    check_int("en_drop_gates", int'({hi0, lo0, hi1, lo1}), 0);
    check_int("en_timer_runs", int'(timer0), 131);
    wait_until(0, 150);
    enable = 1'b1;
    wait_until(0, 250);
    check_int("en_ch0_waits_wrap", int'(lo0), 0);
    check_int("en_ch1_resumed", int'(hi1), 1);
    wait_until(0, 0);
    wait_until(0, 11);
    check_int("en_ch0_resumed", int'(hi0), 1);

    // Asynchronous reset in the middle of a high-side pulse
    wait_until(0, 60);
    check_int("rst_mid_pre_hi", int'(hi0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("rst_mid_gates", int'({hi0, lo0, hi1, lo1}), 0);
    check_int("rst_mid_timer0", int'(timer0), 0);
    check_int("rst_mid_timer1", int'(timer1), PHASE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      last_on[ch] = 0;
      off_cnt[ch] = 0;
    end

    // Randomized run against the model with interlock monitoring
    for (int i = 0; i < 10000; i++) begin
      step();
      if ($urandom_range(999) < 3) enable = ~enable;
      fault     = ($urandom_range(999) < 2);
      fault_clr = ($urandom_range(99) < 1);
      if ($urandom_range(99) < 5) begin
        if ($urandom_range(9) == 0) ict = 16'($urandom);
        else ict = 16'($urandom_range(300));
      end
    end
    fault = 1'b0;
    fault_clr = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
